// File: rtl/regfl_rdout_if.sv
// regfl_rdout_if: output stream bundle of regfl_rdout.
//   dout      word currently presented (rgst_w bits)
//   dout_vld  dout valid
//   dout_rdy  downstream ready; a transfer is dout_vld & dout_rdy
//   idx       register-file index of the word on dout (w bits)
// master = regfl_rdout side, slave = downstream consumer.
interface regfl_rdout_if #(
   parameter int w      = 3,
   parameter int rgst_w = 64
) ();
   logic [rgst_w-1:0] dout;
   logic              dout_vld;
   logic              dout_rdy;
   logic [w-1:0]      idx;

   modport master (output dout, output dout_vld, output idx, input  dout_rdy);
   modport slave  (input  dout, input  dout_vld, input  idx, output dout_rdy);
endinterface

// File: rtl/regfl_rdout.sv
// regfl_rdout: read-side unloader for the SHA-2 register file.
// On start it snapshots the flattened regfl.q bus (2**w words of rgst_w bits).
// It then streams the words out in index order, one per valid/ready transfer,
// and pulses done for one cycle after the last word.
// Ports:
//   clk, rst_b  clock (rising edge), asynchronous active-low reset
//   start       unload request, only looked at in IDLE
//   trunc       (REGFL_RDOUT_TRUNC_EN only) sampled with start; 1 = stop after word N-3
//   rf_q        regfl.q; word k = rf_q[k*rgst_w +: rgst_w]
//   busy        high while streaming and during the done cycle
//   done        one-cycle pulse after the final transfer
//   ob          output stream (dout, dout_vld, dout_rdy, idx)
// Optional feature macro: REGFL_RDOUT_TRUNC_EN (adds trunc, SHA-384 6-word digest).
module regfl_rdout #(
   parameter int w      = 3,
   parameter int rgst_w = 64
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       start,
`ifdef REGFL_RDOUT_TRUNC_EN
   input  logic                       trunc,
`endif
   input  logic [(2**w)*rgst_w-1:0]   rf_q,
   output logic                       busy,
   output logic                       done,
   regfl_rdout_if.master              ob
);

   localparam int           N         = 2**w;
   localparam logic [w-1:0] LAST_FULL = w'(N-1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                      state_q, state_d;
   logic [N-1:0][rgst_w-1:0]    shadow_q, shadow_d;
   logic [w-1:0]                idx_q, idx_d, idx_nx;
   logic [w-1:0]                last_q, last_d, last_sel;
   logic [rgst_w-1:0]           dout_q, dout_d;
   logic                        vld_q, vld_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        xfer;

`ifdef REGFL_RDOUT_TRUNC_EN
   assign last_sel = trunc ? w'(N-3) : LAST_FULL;
`else
   assign last_sel = LAST_FULL;
`endif

   assign xfer   = vld_q & ob.dout_rdy;
   assign idx_nx = idx_q + 1'b1;

   // Next-state and next-output logic. dout is loaded one word ahead so that
   // every output comes straight from a flop; dout_rdy never reaches dout_vld
   // combinationally.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      last_d   = last_q;
      dout_d   = dout_q;
      vld_d    = vld_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shadow_d = rf_q;
               idx_d    = '0;
               last_d   = last_sel;
               dout_d   = rf_q[rgst_w-1:0];
               vld_d    = 1'b1;
               busy_d   = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (idx_q == last_q) begin
                  vld_d   = 1'b0;
                  dout_d  = '0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d  = idx_nx;
                  dout_d = shadow_q[idx_nx];
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            vld_d   = 1'b0;
            dout_d  = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         last_q   <= LAST_FULL;
         dout_q   <= '0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         dout_q   <= dout_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ob.dout     = dout_q;
   assign ob.dout_vld = vld_q;
   assign ob.idx      = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_regfl_rdout.sv
// tb_regfl_rdout: scoreboard bench for regfl_rdout.
// Each start pushes the snapshot words it should produce; the negedge monitor
// pops one entry per transfer and also checks hold-under-backpressure, zero
// dout when not valid, and single-cycle done. A second instance (w=2, rgst_w=32)
// covers the small configuration. Build with REGFL_RDOUT_TRUNC_EN for trunc.
module tb_regfl_rdout;

   logic         clk;
   logic         rst_b;
   logic         start, start_b;
   logic [511:0] rf_q;
   logic [127:0] rf_q_b;
   logic         busy, done, busy_b, done_b;
`ifdef REGFL_RDOUT_TRUNC_EN
   logic         trunc;
`endif

   regfl_rdout_if #(.w(3), .rgst_w(64)) a ();
   regfl_rdout_if #(.w(2), .rgst_w(32)) b ();

   regfl_rdout #(.w(3), .rgst_w(64)) dut (
      .clk(clk), .rst_b(rst_b), .start(start),
`ifdef REGFL_RDOUT_TRUNC_EN
      .trunc(trunc),
`endif
      .rf_q(rf_q), .busy(busy), .done(done), .ob(a)
   );

   regfl_rdout #(.w(2), .rgst_w(32)) dut_b (
      .clk(clk), .rst_b(rst_b), .start(start_b),
`ifdef REGFL_RDOUT_TRUNC_EN
      .trunc(1'b0),
`endif
      .rf_q(rf_q_b), .busy(busy_b), .done(done_b), .ob(b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  idx;
      logic [63:0] dat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   pat[4] = '{1, 0, 0, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] wd(input int k);
      return 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive start for one cycle and queue the expected words from the current rf_q.
   task automatic kick(input int n);
      for (int k = 0; k < n; k++) sb.push_back('{idx: 3'(k), dat: rf_q[k*64 +: 64]});
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Run from cycle 1 until done; cyc returns the cycle index of the done pulse.
   task automatic run_stream(input int mode, output int cyc);
      cyc = 1;
      for (int i = 0; i < 200; i++) begin
         case (mode)
            1:       a.dout_rdy = pat[i % 4] != 0;
            2:       a.dout_rdy = $urandom_range(0, 1) != 0;
            default: a.dout_rdy = 1'b1;
         endcase
         if (mode == 2) begin
            start = busy;
            for (int j = 0; j < 16; j++) rf_q[j*32 +: 32] = $urandom;
         end
         step();
         cyc++;
         if (done) break;
      end
      chk("stream_done", done, 1);
   endtask

   // start during the DONE cycle must be ignored; FSM then sits in IDLE.
   task automatic finish_stream();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("idle_vld", a.dout_vld, 0);
      chk("idle_busy", busy, 0);
      step();
      chk("no_restart", a.dout_vld, 0);
   endtask

   // Scoreboard monitor
   logic        stl, prev_done;
   logic [63:0] hd;
   logic [2:0]  hi;
   initial begin stl = 1'b0; prev_done = 1'b0; hd = '0; hi = '0; end

   always @(negedge clk) begin
      if (!rst_b) begin
         stl       = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (stl) begin
            chk("hold_dout", a.dout, hd);
            chk("hold_idx", 64'(a.idx), 64'(hi));
         end
         if (a.dout_vld && a.dout_rdy) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("dout", a.dout, e.dat);
               chk("idx", 64'(a.idx), 64'(e.idx));
            end
         end
         if (!a.dout_vld) chk("dout_idle0", a.dout, 0);
         if (done) begin
            done_cnt++;
            chk("done_pulse", 64'(prev_done), 0);
         end
         stl       = a.dout_vld && !a.dout_rdy;
         hd        = a.dout;
         hi        = a.idx;
         prev_done = done;
      end
   end

   initial begin
      int cyc;
      int base;
      rst_b      = 1'b0;
      start      = 1'b0;
      start_b    = 1'b0;
      a.dout_rdy = 1'b0;
      b.dout_rdy = 1'b1;
`ifdef REGFL_RDOUT_TRUNC_EN
      trunc      = 1'b0;
`endif
      for (int k = 0; k < 8; k++) rf_q[k*64 +: 64] = wd(k);
      for (int k = 0; k < 4; k++) rf_q_b[k*32 +: 32] = 32'hA5A5_0000 + 32'(k * 17);
      step();
      step();
      chk("rst_dout", a.dout, 0);
      chk("rst_vld", a.dout_vld, 0);
      chk("rst_idx", 64'(a.idx), 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_b = 1'b1;
      step();

      // 1: full stream at rdy=1, exact latency
      a.dout_rdy = 1'b1;
      kick(8);
      for (int k = 0; k < 8; k++) begin
         chk("t1_vld", a.dout_vld, 1);
         chk("t1_idx", 64'(a.idx), 64'(k));
         chk("t1_dout", a.dout, wd(k));
         chk("t1_nodone", done, 0);
         step();
      end
      chk("t1_done", done, 1);
      chk("t1_vld_off", a.dout_vld, 0);
      chk("t1_busy_done", busy, 1);
      step();
      chk("t1_done_off", done, 0);
      chk("t1_idle_busy", busy, 0);
      step();

      // 2: backpressure pattern 1,0,0,1
      base = done_cnt;
      kick(8);
      run_stream(1, cyc);
      finish_stream();
      chk("t2_sb_empty", 64'(sb.size()), 0);
      chk("t2_done_cnt", 64'(done_cnt - base), 1);

      // 3: start held during SEND/DONE, rf_q scrambled after snapshot
      for (int k = 0; k < 8; k++) rf_q[k*64 +: 64] = ~wd(k + 3);
      base = done_cnt;
      kick(8);
      run_stream(2, cyc);
      a.dout_rdy = 1'b1;
      finish_stream();
      step();
      chk("t3_sb_empty", 64'(sb.size()), 0);
      chk("t3_done_cnt", 64'(done_cnt - base), 1);

      // 4: async reset mid-stream, then restart from idx 0
      for (int k = 0; k < 8; k++) rf_q[k*64 +: 64] = wd(k);
      kick(8);
      step(); step(); step();
      chk("t4_idx3", 64'(a.idx), 3);
      step();
      #2;
      sb.delete();
      rst_b = 1'b0;
      #1;
      chk("t4_rst_dout", a.dout, 0);
      chk("t4_rst_vld", a.dout_vld, 0);
      chk("t4_rst_idx", 64'(a.idx), 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      step();
      rst_b = 1'b1;
      step();
      chk("t4_stays_idle", a.dout_vld, 0);
      kick(8);
      chk("t4_restart_idx", 64'(a.idx), 0);
      chk("t4_restart_dout", a.dout, wd(0));
      run_stream(0, cyc);
      chk("t4_done_cyc", 64'(cyc), 9);
      finish_stream();
      chk("t4_sb_empty", 64'(sb.size()), 0);

`ifdef REGFL_RDOUT_TRUNC_EN
      // 5: truncated 6-word stream, then full stream with trunc=0
      trunc = 1'b1;
      kick(6);
      trunc = 1'b0;
      run_stream(0, cyc);
      chk("t5_trunc_cyc", 64'(cyc), 7);
      finish_stream();
      chk("t5_trunc_sb", 64'(sb.size()), 0);
      kick(8);
      run_stream(0, cyc);
      chk("t5_full_cyc", 64'(cyc), 9);
      finish_stream();
      chk("t5_full_sb", 64'(sb.size()), 0);
`endif

      // 6: w=2, rgst_w=32 instance
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t6_vld", b.dout_vld, 1);
         chk("t6_idx", 64'(b.idx), 64'(k));
         chk("t6_dout", 64'(b.dout), 64'(32'hA5A5_0000 + 32'(k * 17)));
         step();
      end
      chk("t6_done", done_b, 1);
      chk("t6_vld_off", b.dout_vld, 0);
      step();
      chk("t6_done_off", done_b, 0);
      chk("t6_busy_off", busy_b, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
